// File: rtl/xlr_mem_responder.sv
// Banked line memory serving the accelerator xlr_mem port plus a host fill/dump port.
// Optional XLR_MEM_BYPASS_EN: same-cycle accel rd+wr on a bank returns the newly written line.
module xlr_mem_responder #(
    parameter int NUM_MEMS           = 2,
    parameter int LOG2_LINES_PER_MEM = 8,
    parameter int LINE_W             = 256,
    parameter int MEM_SEL_W          = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_MEMS*LOG2_LINES_PER_MEM-1:0] xlr_mem_addr,
    input  logic [NUM_MEMS*LINE_W-1:0]             xlr_mem_wdata,
    input  logic [NUM_MEMS*(LINE_W/8)-1:0]         xlr_mem_be,
    input  logic [NUM_MEMS-1:0]                    xlr_mem_rd,
    input  logic [NUM_MEMS-1:0]                    xlr_mem_wr,
    output logic [NUM_MEMS*LINE_W-1:0]             xlr_mem_rdata,
    input  logic                                   host_req_valid,
    output logic                                   host_req_ready,
    input  logic                                   host_req_wr,
    input  logic [MEM_SEL_W-1:0]                   host_req_mem,
    input  logic [LOG2_LINES_PER_MEM-1:0]          host_req_addr,
    input  logic [LINE_W-1:0]                      host_req_wdata,
    output logic                                   host_rsp_valid,
    output logic [LINE_W-1:0]                      host_rsp_rdata
);
    localparam int AW    = LOG2_LINES_PER_MEM;
    localparam int BE_W  = LINE_W / 8;
    localparam int LINES = 1 << AW;

    // Host handshake: a request transfers on a rising edge where host_req_valid && host_req_ready.
    typedef enum logic [1:0] {IDLE, EXEC, RSP} state_t;
    state_t state, state_next;

    logic              h_wr;
    logic [MEM_SEL_W-1:0] h_mem;
    logic [AW-1:0]     h_addr;
    logic [LINE_W-1:0] h_wdata;
    logic [LINE_W-1:0] rsp_q;
    logic [NUM_MEMS-1:0] host_sel;
    logic [LINE_W-1:0] host_line [NUM_MEMS];
    logic              bank_valid;
    logic              bank_busy;
    logic              exec_go;
    logic [LINE_W-1:0] host_rd_line;

    for (genvar m = 0; m < NUM_MEMS; m++) begin : g_bank
        logic [LINE_W-1:0] lines [LINES];
        logic [AW-1:0]     addr;
        logic [LINE_W-1:0] wdata;
        logic [BE_W-1:0]   be;
        logic [LINE_W-1:0] rd_line;
        logic [LINE_W-1:0] rdata_q;

        assign addr  = xlr_mem_addr[m*AW +: AW];
        assign wdata = xlr_mem_wdata[m*LINE_W +: LINE_W];
        assign be    = xlr_mem_be[m*BE_W +: BE_W];

`ifdef XLR_MEM_BYPASS_EN
        logic [LINE_W-1:0] new_line;
        always_comb begin
            new_line = lines[addr];
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) new_line[b*8 +: 8] = wdata[b*8 +: 8];
            end
        end
        assign rd_line = xlr_mem_wr[m] ? new_line : lines[addr];
`else
        assign rd_line = lines[addr];
`endif

        assign host_sel[m]  = (int'(h_mem) == m);
        assign host_line[m] = lines[h_addr];

        // The host only executes on a bank the accelerator leaves idle, so the two writers never collide.
        always_ff @(posedge clk) begin
            if (xlr_mem_wr[m]) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (be[b]) lines[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end else if (exec_go && h_wr && host_sel[m]) begin
                lines[h_addr] <= h_wdata;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rdata_q <= '0;
            end else if (xlr_mem_rd[m]) begin
                rdata_q <= rd_line;
            end
        end

        assign xlr_mem_rdata[m*LINE_W +: LINE_W] = rdata_q;
    end

    always_comb begin
        bank_valid   = 1'b0;
        bank_busy    = 1'b0;
        host_rd_line = '0;
        for (int m = 0; m < NUM_MEMS; m++) begin
            if (host_sel[m]) begin
                bank_valid   = 1'b1;
                bank_busy    = xlr_mem_rd[m] | xlr_mem_wr[m];
                host_rd_line = host_line[m];
            end
        end
    end

    always_comb begin
        state_next     = state;
        host_req_ready = 1'b0;
        host_rsp_valid = 1'b0;
        exec_go        = 1'b0;
        case (state)
            IDLE: begin
                host_req_ready = 1'b1;
                if (host_req_valid) state_next = EXEC;
            end
            EXEC: begin
                if (!bank_busy) begin
                    exec_go    = 1'b1;
                    state_next = RSP;
                end
            end
            RSP: begin
                host_rsp_valid = 1'b1;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign host_rsp_rdata = host_rsp_valid ? rsp_q : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            h_wr    <= 1'b0;
            h_mem   <= '0;
            h_addr  <= '0;
            h_wdata <= '0;
            rsp_q   <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && host_req_valid) begin
                h_wr    <= host_req_wr;
                h_mem   <= host_req_mem;
                h_addr  <= host_req_addr;
                h_wdata <= host_req_wdata;
            end
            // Write acks and out-of-range banks answer with zero data.
            if (exec_go) rsp_q <= (!h_wr && bank_valid) ? host_rd_line : '0;
        end
    end

endmodule

// File: tb/tb_xlr_mem_responder.sv
// Directed plus randomized bench for xlr_mem_responder against a line-array reference model.
// Build with +define+XLR_MEM_BYPASS_EN to check the bypass variant.
module tb_xlr_mem_responder;
    localparam int NM = 2;
    localparam int AW = 8;
    localparam int LW = 256;
    localparam int BW = LW / 8;
    localparam int SW = 2;
`ifdef XLR_MEM_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NM*AW-1:0]  xlr_mem_addr;
    logic [NM*LW-1:0]  xlr_mem_wdata;
    logic [NM*BW-1:0]  xlr_mem_be;
    logic [NM-1:0]     xlr_mem_rd;
    logic [NM-1:0]     xlr_mem_wr;
    logic [NM*LW-1:0]  xlr_mem_rdata;
    logic              host_req_valid;
    logic              host_req_ready;
    logic              host_req_wr;
    logic [SW-1:0]     host_req_mem;
    logic [AW-1:0]     host_req_addr;
    logic [LW-1:0]     host_req_wdata;
    logic              host_rsp_valid;
    logic [LW-1:0]     host_rsp_rdata;

    always #5 clk = ~clk;

    xlr_mem_responder #(
        .NUM_MEMS(NM), .LOG2_LINES_PER_MEM(AW), .LINE_W(LW), .MEM_SEL_W(SW)
    ) dut (
        .clk(clk), .rst(rst),
        .xlr_mem_addr(xlr_mem_addr), .xlr_mem_wdata(xlr_mem_wdata), .xlr_mem_be(xlr_mem_be),
        .xlr_mem_rd(xlr_mem_rd), .xlr_mem_wr(xlr_mem_wr), .xlr_mem_rdata(xlr_mem_rdata),
        .host_req_valid(host_req_valid), .host_req_ready(host_req_ready), .host_req_wr(host_req_wr),
        .host_req_mem(host_req_mem), .host_req_addr(host_req_addr), .host_req_wdata(host_req_wdata),
        .host_rsp_valid(host_rsp_valid), .host_rsp_rdata(host_rsp_rdata)
    );

    // Reference model: plain line arrays, with a flag for lines whose content is defined.
    logic [LW-1:0] model [NM][256];
    bit            known [NM][256];
    logic [LW-1:0] rd_exp [NM];
    bit            rd_ok  [NM];
    logic [LW-1:0] exp_q [$];
    int            tests = 0;
    int            fails = 0;

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] merge(input logic [LW-1:0] old, input logic [LW-1:0] d,
                                             input logic [BW-1:0] be);
        merge = old;
        for (int b = 0; b < BW; b++) begin
            if (be[b]) merge[b*8 +: 8] = d[b*8 +: 8];
        end
    endfunction

    function automatic logic [LW-1:0] rand_line();
        for (int i = 0; i < LW / 32; i++) rand_line[i*32 +: 32] = $urandom;
    endfunction

    task automatic accel_idle();
        xlr_mem_rd = '0;
        xlr_mem_wr = '0;
    endtask

    task automatic set_accel(input int m, input bit r, input bit w, input logic [AW-1:0] a,
                             input logic [LW-1:0] d, input logic [BW-1:0] be);
        xlr_mem_rd[m]            = r;
        xlr_mem_wr[m]            = w;
        xlr_mem_addr[m*AW +: AW] = a;
        xlr_mem_wdata[m*LW +: LW] = d;
        xlr_mem_be[m*BW +: BW]   = be;
    endtask

    task automatic reset_rd_model();
        for (int m = 0; m < NM; m++) begin
            rd_exp[m] = '0;
            rd_ok[m]  = 1'b1;
        end
    endtask

    // Applies the accelerator inputs currently driven for one clock, then checks every bank's rdata.
    task automatic accel_step();
        logic [AW-1:0] a;
        logic [LW-1:0] d;
        logic [LW-1:0] old;
        logic [BW-1:0] be;
        for (int m = 0; m < NM; m++) begin
            a   = xlr_mem_addr[m*AW +: AW];
            d   = xlr_mem_wdata[m*LW +: LW];
            be  = xlr_mem_be[m*BW +: BW];
            old = model[m][a];
            if (xlr_mem_rd[m]) begin
                rd_exp[m] = (BYP && xlr_mem_wr[m]) ? merge(old, d, be) : old;
                rd_ok[m]  = known[m][a] || (BYP && xlr_mem_wr[m] && (&be));
            end
            if (xlr_mem_wr[m]) begin
                model[m][a] = merge(old, d, be);
                if (&be) known[m][a] = 1'b1;
            end
        end
        tick();
        for (int m = 0; m < NM; m++) begin
            if (rd_ok[m]) check($sformatf("accel_rdata%0d", m), xlr_mem_rdata[m*LW +: LW], rd_exp[m]);
        end
    endtask

    // One complete host request; lat = cycles from entering EXEC until the response pulse.
    task automatic host_txn(input bit w, input logic [SW-1:0] mem, input logic [AW-1:0] a,
                            input logic [LW-1:0] d, output int lat);
        logic [LW-1:0] exp;
        bit            ok;
        exp = '0;
        ok  = 1'b1;
        if (int'(mem) < NM) begin
            if (w) begin
                model[int'(mem)][a] = d;
                known[int'(mem)][a] = 1'b1;
            end else begin
                exp = model[int'(mem)][a];
                ok  = known[int'(mem)][a];
            end
        end
        exp_q.push_back(exp);
        host_req_valid = 1'b1;
        host_req_wr    = w;
        host_req_mem   = mem;
        host_req_addr  = a;
        host_req_wdata = d;
        check("req_ready", {255'd0, host_req_ready}, 256'd1);
        tick();
        host_req_valid = 1'b0;
        host_req_addr  = AW'($urandom);
        host_req_wdata = rand_line();
        host_req_wr    = ~w;
        check("exec_ready", {255'd0, host_req_ready}, 256'd0);
        lat = 0;
        while (!host_rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("rsp_valid", {255'd0, host_rsp_valid}, 256'd1);
        exp = exp_q.pop_front();
        if (ok) check("rsp_rdata", host_rsp_rdata, exp);
        tick();
        check("rsp_pulse", {255'd0, host_rsp_valid}, 256'd0);
        check("idle_ready", {255'd0, host_req_ready}, 256'd1);
    endtask

    initial begin
        int            lat;
        int            lat2;
        logic [LW-1:0] old7;
        logic [LW-1:0] line;

        rst = 1'b1;
        xlr_mem_addr = '0; xlr_mem_wdata = '0; xlr_mem_be = '0;
        accel_idle();
        host_req_valid = 1'b0; host_req_wr = 1'b0; host_req_mem = '0;
        host_req_addr = '0; host_req_wdata = '0;
        for (int m = 0; m < NM; m++) begin
            for (int i = 0; i < 256; i++) known[m][i] = 1'b0;
        end
        reset_rd_model();
        tick();
        tick();
        check("rst_ready", {255'd0, host_req_ready}, 256'd1);
        check("rst_rsp_valid", {255'd0, host_rsp_valid}, 256'd0);
        check("rst_rsp_rdata", host_rsp_rdata, '0);
        check("rst_rdata0", xlr_mem_rdata[0 +: LW], '0);
        check("rst_rdata1", xlr_mem_rdata[LW +: LW], '0);
        rst = 1'b0;
        tick();

        // Fill lines 0..31 of both banks through the host port.
        for (int m = 0; m < NM; m++) begin
            for (int i = 0; i < 32; i++) host_txn(1'b1, SW'(m), AW'(i), rand_line(), lat);
        end

        // Host write then read of bank0 line 0x05.
        host_txn(1'b1, 2'd0, 8'h05, {32{8'hA5}}, lat);
        check("wr_latency", 256'(lat), 256'd1);
        host_txn(1'b0, 2'd0, 8'h05, '0, lat);
        check("rd_latency", 256'(lat), 256'd1);
        check("a5_model", model[0][8'h05], {32{8'hA5}});

        // Accelerator byte-enable writes on bank1 line 0x10.
        set_accel(1, 1'b0, 1'b1, 8'h10, {LW{1'b1}}, {BW{1'b1}});
        accel_step();
        set_accel(1, 1'b0, 1'b1, 8'h10, '0, 32'h0000_000F);
        accel_step();
        set_accel(1, 1'b1, 1'b0, 8'h10, '0, '0);
        accel_step();
        accel_idle();
        check("be_merge", xlr_mem_rdata[LW +: LW], {{224{1'b1}}, 32'h0});
        accel_step();

        // Host read on bank0 stalled for 4 cycles by an accelerator read.
        set_accel(0, 1'b1, 1'b0, 8'h03, '0, '0);
        fork
            host_txn(1'b0, 2'd0, 8'h03, '0, lat);
            begin
                repeat (5) tick();
                xlr_mem_rd[0] = 1'b0;
            end
        join
        check("stall_latency", 256'(lat), 256'd5);
        rd_exp[0] = model[0][8'h03];
        rd_ok[0]  = known[0][8'h03];

        // Host access to bank1 while bank0 is busy proceeds unstalled.
        set_accel(0, 1'b1, 1'b0, 8'h03, '0, '0);
        fork
            host_txn(1'b0, 2'd1, 8'h07, '0, lat2);
            begin
                repeat (3) tick();
                xlr_mem_rd[0] = 1'b0;
            end
        join
        check("other_bank_latency", 256'(lat2), 256'd1);

        // Same-cycle accel rd+wr on bank0 line 0x20.
        host_txn(1'b1, 2'd0, 8'h20, {32{8'h11}}, lat);
        set_accel(0, 1'b1, 1'b1, 8'h20, {32{8'h22}}, {BW{1'b1}});
        accel_step();
        accel_idle();
        check("rd_wr_same", xlr_mem_rdata[0 +: LW], BYP ? {32{8'h22}} : {32{8'h11}});
        set_accel(0, 1'b1, 1'b0, 8'h20, '0, '0);
        accel_step();
        accel_idle();
        check("rd_after_wr", xlr_mem_rdata[0 +: LW], {32{8'h22}});

        // Out-of-range bank: acked with zero data, no side effect.
        host_txn(1'b1, 2'd3, 8'h10, rand_line(), lat);
        host_txn(1'b0, 2'd3, 8'h10, '0, lat);
        host_txn(1'b0, 2'd0, 8'h10, '0, lat);
        host_txn(1'b0, 2'd1, 8'h10, '0, lat);

        // Random accelerator traffic on both banks.
        for (int i = 0; i < 80; i++) begin
            for (int m = 0; m < NM; m++) begin
                set_accel(m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          AW'($urandom_range(0, 31)), rand_line(),
                          ($urandom_range(0, 3) == 0) ? {BW{1'b1}} : BW'($urandom));
            end
            accel_step();
        end
        accel_idle();
        accel_step();

        // Random host traffic, including out-of-range banks.
        for (int i = 0; i < 30; i++) begin
            host_txn(1'($urandom_range(0, 1)), SW'($urandom_range(0, 3)), AW'($urandom_range(0, 31)),
                     rand_line(), lat);
        end
        accel_step();

        // Reset while a host write sits stalled in EXEC: the write is lost.
        old7 = model[0][8'h07];
        set_accel(0, 1'b1, 1'b0, 8'h09, '0, '0);
        host_req_valid = 1'b1;
        host_req_wr    = 1'b1;
        host_req_mem   = 2'd0;
        host_req_addr  = 8'h07;
        host_req_wdata = ~old7;
        tick();
        host_req_valid = 1'b0;
        tick();
        check("stalled_ready", {255'd0, host_req_ready}, 256'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_ready", {255'd0, host_req_ready}, 256'd1);
        check("mid_rst_rsp_valid", {255'd0, host_rsp_valid}, 256'd0);
        check("mid_rst_rsp_rdata", host_rsp_rdata, '0);
        check("mid_rst_rdata0", xlr_mem_rdata[0 +: LW], '0);
        check("mid_rst_rdata1", xlr_mem_rdata[LW +: LW], '0);
        tick();
        accel_idle();
        rst = 1'b0;
        reset_rd_model();
        tick();
        host_txn(1'b0, 2'd0, 8'h07, '0, lat);
        line = host_rsp_rdata;
        check("lost_write_latency", 256'(lat), 256'd1);
        set_accel(0, 1'b1, 1'b0, 8'h07, '0, '0);
        accel_step();
        accel_idle();
        check("lost_write_line", xlr_mem_rdata[0 +: LW], old7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/xlr_mem_responder.md
Name: xlr_mem_responder

Overview:
- Memory-side end of the xlr_mem interface: a synthesizable banked line memory that services accelerator requests (addr/wdata/be/rd/wr) and returns mem_rdata.
- Adds a host fill/dump port with valid/ready handshake, so the host can load operands before a run and read results after it.
- Replaces the ad-hoc bench memory model for xbox_xlr_* accelerators. Sits between the accelerator's xlr_mem port and the host-side loader.

Parameters:
- NUM_MEMS, 2, number of independent banks.
- LOG2_LINES_PER_MEM, 8, address width per bank (256 lines).
- LINE_W, 256, bits per line. Must be a multiple of 8; BE_W = LINE_W/8.
- MEM_SEL_W, 1, host bank-select width; must satisfy 2**MEM_SEL_W >= NUM_MEMS.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- xlr_mem_addr  in  NUM_MEMS*LOG2_LINES_PER_MEM  per-bank line address, bank m at slice m.
- xlr_mem_wdata  in  NUM_MEMS*LINE_W  per-bank write data.
- xlr_mem_be  in  NUM_MEMS*BE_W  per-bank byte enables.
- xlr_mem_rd  in  NUM_MEMS  per-bank read strobe.
- xlr_mem_wr  in  NUM_MEMS  per-bank write strobe.
- xlr_mem_rdata  out  NUM_MEMS*LINE_W  per-bank registered read data.
- host_req_valid  in  1  host request valid.
- host_req_ready  out  1  responder can accept a host request.
- host_req_wr  in  1  1 = write full line, 0 = read.
- host_req_mem  in  MEM_SEL_W  target bank.
- host_req_addr  in  LOG2_LINES_PER_MEM  target line.
- host_req_wdata  in  LINE_W  write data; all bytes are written.
- host_rsp_valid  out  1  one-cycle completion pulse.
- host_rsp_rdata  out  LINE_W  read data (0 for write acks).

Behaviour:
- Reset (async, rst=1):
  - xlr_mem_rdata = 0, host_rsp_valid = 0, host_rsp_rdata = 0.
  - FSM = IDLE, host_req_ready = 1.
  - Storage arrays are not cleared.
- Accelerator port, per bank m, independent:
  - xlr_mem_wr[m]: bytes with be=1 are written at the edge; bytes with be=0 are untouched.
  - xlr_mem_rd[m]: rdata[m] carries mem[addr] one cycle after the strobe (latency 1). rdata[m] holds its value until the next rd on that bank.
  - rd and wr on the same address in the same cycle: read returns the OLD line (read-before-write).
- Host FSM, states IDLE / EXEC / RSP:
  - IDLE: ready=1. On valid&&ready, capture wr/mem/addr/wdata into a holding register and go to EXEC.
  - EXEC: ready=0. Executes when the captured bank has neither xlr_mem_rd nor xlr_mem_wr asserted this cycle; otherwise it stalls in EXEC (accelerator has absolute priority; no starvation guard). On execute, a write commits the full line at this edge and a read samples the array; then go to RSP.
  - RSP: host_rsp_valid=1 for exactly one cycle. rdata = read line, or 0 for a write. Go to IDLE.
  - Minimum host turnaround: 3 cycles per request, so the next request is accepted in the cycle after RSP.
- Host and accelerator never access the same bank in the same cycle. Different banks proceed concurrently.
- host_req_mem >= NUM_MEMS: the request is accepted, completes in RSP with rdata=0, and has no write side effect.
- host_req_valid dropped while in EXEC/RSP: ignored, since the request is already captured.
- Reset asserted mid-operation: FSM returns to IDLE immediately. A pending host write that has not yet executed is lost. Completed writes persist.

Optional Feature:
- Macro XLR_MEM_BYPASS_EN.
- Defined: an accelerator rd and wr to the same bank and address in the same cycle return the NEW line, i.e. the old line with the be-selected bytes replaced by wdata.
- Undefined: read-before-write (old line) as above. All other behaviour is identical in both builds.

Test Plan:
- Host write bank0 line 0x05 = 0xA5 repeated, then host read bank0 line 0x05 -> host_rsp_valid pulses with rdata 0xA5 repeated; each request takes 3 cycles from handshake to IDLE.
- Accel wr bank1 addr 0x10 wdata all 0xFF be all 1, then wr wdata all 0x00 be = 0x0000_000F, then rd addr 0x10 -> one cycle later rdata[1] has low 4 bytes 0x00 and remaining bytes 0xFF.
- Host read bank0 addr 0x03 while accel holds xlr_mem_rd[0]=1 for 4 cycles -> FSM stays in EXEC 4 cycles, rsp_valid occurs 1 cycle after accel releases; a concurrent host access to bank1 shows no stall.
- Same-cycle accel rd+wr bank0 addr 0x20 (old 0x11.., new 0x22.., be all 1) -> rdata 0x11.. without XLR_MEM_BYPASS_EN, 0x22.. with it.
- Host req_mem=3 with NUM_MEMS=2, wr=1 -> rsp_valid with rdata 0; banks 0/1 unchanged on subsequent readback.
- Assert rst while FSM in EXEC (stalled host write) -> outputs 0, ready=1 next cycle, target line keeps its pre-request value.
